bus_arbiter: RTL

Two-master arbiter that shares the CPU's 16-bit address / 8-bit data bus between the 6502-style CPU and one DMA master (e.g. an SD-card block mover). It sits between the masters and the address decoder/data mux, presents a single next-cycle bus request downstream, and stalls the CPU through its enable whenever the DMA master owns the bus. The DMA burst length is bounded so the CPU always makes progress.

---
 rtl/bus_arbiter_pkg.sv | 16 +
 rtl/bus_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and widths for the CPU/DMA bus arbiter
//
// Purpose : bus ownership encoding and bus widths used by bus_arbiter.
// Contents: arb_state_t (ARB_CPU, ARB_DMA), ADDR_W, DATA_W.

package bus_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master (CPU / DMA) bus arbiter with bounded DMA bursts
//
// Purpose : shares the CPU's next-cycle address/data bus with one DMA master.
//           The CPU is stalled through cpu_enable while the DMA master owns
//           the bus; a DMA burst ends after MAX_BURST completed accesses and
//           the CPU then completes at least one access before a regrant.
// Ports   : clk, reset (sync, active-high)
//           cpu_next_addr/rd/we, cpu_do -> CPU request; cpu_enable, cpu_di back
//           dma_req/addr/rd/we/do       -> DMA request; dma_gnt, dma_ack,
//                                          dma_rvalid, dma_di back
//           bus_next_addr/rd/we, bus_do -> decoder / peripherals
//           bus_enable, bus_di          <- decoder ready, read data mux

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_next_addr,
  input  logic              cpu_next_rd,
  input  logic              cpu_next_we,
  input  logic [DATA_W-1:0] cpu_do,
  output logic              cpu_enable,
  output logic [DATA_W-1:0] cpu_di,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_rd,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_do,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_di,
  output logic [ADDR_W-1:0] bus_next_addr,
  output logic              bus_next_rd,
  output logic              bus_next_we,
  output logic [DATA_W-1:0] bus_do,
  input  logic              bus_enable,
  input  logic [DATA_W-1:0] bus_di
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_next;
  logic             hold, hold_next;
  logic             rvalid;

  // Bus mux and strobes depend only on the registered owner, so dma_req and
  // cpu_* never reach ownership combinationally; bus_enable does reach the
  // strobes so a slow device stalls the current owner in the same cycle.
  always_comb begin
    bus_next_addr = cpu_next_addr;
    bus_next_rd   = cpu_next_rd;
    bus_next_we   = cpu_next_we;
    bus_do        = cpu_do;
    cpu_enable    = 1'b0;
    dma_gnt       = 1'b0;
    dma_ack       = 1'b0;
    if (state == ARB_DMA) begin
      bus_next_addr = dma_addr;
      bus_next_rd   = dma_rd & dma_req;
      bus_next_we   = dma_we & dma_req;
      bus_do        = dma_do;
      dma_gnt       = 1'b1;
      dma_ack       = dma_req & bus_enable;
    end else begin
      cpu_enable    = bus_enable;
    end
  end

  // Both masters see the read mux; each samples only on its own strobe.
  assign cpu_di     = bus_di;
  assign dma_di     = bus_di;
  assign dma_rvalid = rvalid;

  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    hold_next      = hold;
    // One completed CPU access releases the fairness hold.
    if (cpu_enable) hold_next = 1'b0;
    case (state)
      ARB_DMA: begin
        if (dma_ack) burst_cnt_next = burst_cnt + 1'b1;
        // Burst exhaustion takes priority over a simultaneous request drop
        // so the CPU is still guaranteed its access before a regrant.
        if (dma_ack && (burst_cnt == LAST_CNT)) begin
          state_next = ARB_CPU;
          hold_next  = 1'b1;
        end else if (!dma_req) begin
          state_next = ARB_CPU;
        end
      end
      default: begin
        if (dma_req && bus_enable && !hold) begin
          state_next     = ARB_DMA;
          burst_cnt_next = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_CPU;
      burst_cnt <= '0;
      hold      <= 1'b0;
      rvalid    <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
      hold      <= hold_next;
      rvalid    <= dma_ack & dma_rd;
    end
  end

endmodule
